// File: rtl/dsa_pkg.sv
// rtl/dsa_pkg.sv - shared types and helpers for the DSA signer and verifier
// Contents:
//   DSA_W        default operand width
//   dsa_state_e  verifier FSM state encoding
//   mm_step_e    step within a multiply sequence (square/multiply/precompute)
//   mm_bsel_e    multiplier b-operand select for exponent multiply steps
//   shamir_bsel  maps an exponent bit pair (e1,e2) onto mm_bsel_e
package dsa_pkg;

  localparam int unsigned DSA_W = 512;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_INV,
    ST_U1,
    ST_U2,
    ST_EXP,
    ST_EXPG,
    ST_EXPY,
    ST_MULGY,
    ST_RED,
    ST_CMP,
    ST_DONE
  } dsa_state_e;

  // In exponent states STEP_0 squares and STEP_1 multiplies by the selected
  // base; in U1 they are the two sequential multiplies.
  typedef enum logic [1:0] {
    STEP_0,
    STEP_1,
    STEP_PRE
  } mm_step_e;

  typedef enum logic [1:0] {
    BSEL_ONE = 2'd0,
    BSEL_G   = 2'd1,
    BSEL_Y   = 2'd2,
    BSEL_GY  = 2'd3
  } mm_bsel_e;

  // e1 is the bit of the g exponent, e2 the bit of the y exponent.
  function automatic mm_bsel_e shamir_bsel(input logic e1, input logic e2);
    return mm_bsel_e'({e2, e1});
  endfunction

endpackage

// File: rtl/dsa_mod_mul.sv
// rtl/dsa_mod_mul.sv - serial interleaved shift-add modular multiplier
// Computes res = a*b mod m, MSB-first over the W bits of a, one bit per cycle.
// Requires b < m; a is unrestricted. A start accepted while idle gives a
// one-cycle done pulse W cycles later, with res valid from then on.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (aborts any operation)
//   start        launch request, ignored while an operation is running
//   a, b, m      operands, captured at start
//   done         one-cycle completion pulse
//   res          result, < m
module dsa_mod_mul
  import dsa_pkg::*;
#(
  parameter int unsigned W = DSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         done,
  output logic [W-1:0] res
);

  localparam int unsigned CW = $clog2(W + 1);

  logic          run_q, run_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
  logic [W+1:0]  acc_q, acc_d;
  logic [W+1:0]  m_ext, dbl_raw, dbl, sum_raw, sum;

  // acc stays below m, so two spare bits cover 2*acc + b without overflow.
  assign m_ext   = {2'b00, m_q};
  assign dbl_raw = acc_q << 1;
  assign dbl     = (dbl_raw >= m_ext) ? (dbl_raw - m_ext) : dbl_raw;
  assign sum_raw = dbl + (a_q[W-1] ? {2'b00, b_q} : '0);
  assign sum     = (sum_raw >= m_ext) ? (sum_raw - m_ext) : sum_raw;

  always_comb begin
    run_d  = run_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    acc_d  = acc_q;
    if (run_q) begin
      acc_d = sum;
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(W);
      a_d   = a;
      b_d   = b;
      m_d   = m;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      m_q    <= m_d;
      acc_q  <= acc_d;
    end
  end

  assign done = done_q;
  assign res  = acc_q[W-1:0];

endmodule

// File: rtl/dsa_verify.sv
// rtl/dsa_verify.sv - iterative DSA signature verifier around one serial mulmod
// Accepts when ((g^u1 * y^u2) mod p) mod q == r, with w = s^-1 mod q,
// u1 = Hm*w mod q, u2 = r*w mod q. Exponent loops run a fixed W iterations.
// Build option: SHAMIR_TRICK_EN selects a joint g/y exponentiation pass using
// a precomputed g*y mod p; otherwise g^u1, y^u2 and their product are separate.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                level request, launches a verify from IDLE
//   p,q,g,y,Hm,r,s    domain params, public key, hash, signature (captured at launch)
//   busy              high from launch until DONE
//   done              high while in DONE, held until en drops
//   valid             1 = signature accepted, qualified by done
module dsa_verify
  import dsa_pkg::*;
#(
  parameter int unsigned W = DSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] g,
  input  logic [W-1:0] y,
  input  logic [W-1:0] Hm,
  input  logic [W-1:0] r,
  input  logic [W-1:0] s,
  output logic         busy,
  output logic         done,
  output logic         valid
);

  localparam int unsigned   BW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]  ONE     = W'(1);
  localparam logic [BW-1:0] BIT_TOP = BW'(W - 1);

  dsa_state_e    state_q, state_d;
  mm_step_e      step_q, step_d, step_adv;
  logic          wait_q, wait_d;
  logic [BW-1:0] bit_q, bit_d, bit_adv;
  logic [W-1:0]  p_q, p_d, q_q, q_d, g_q, g_d, y_q, y_d;
  logic [W-1:0]  hm_q, hm_d, r_q, r_d, s_q, s_d;
  logic [W-1:0]  w_q, w_d, u1_q, u1_d, u2_q, u2_d;
  // acc: running accumulator; aux: g^u1 (separate passes) or g*y (joint pass)
  logic [W-1:0]  acc_q, acc_d, aux_q, aux_d;
  logic          valid_q, valid_d;

  logic          mm_start, mm_done;
  logic [W-1:0]  mm_a, mm_b, mm_m, mm_res;
  logic [W-1:0]  inv_e, exp_b;
  mm_bsel_e      exp_bsel;
  logic          loop_last, sig_bad;

  assign inv_e     = q_q - W'(2);
  assign sig_bad   = (r_q == '0) || (r_q >= q_q) || (s_q == '0) || (s_q >= q_q);
  assign loop_last = (step_q == STEP_1) && (bit_q == '0);
  assign step_adv  = (step_q == STEP_0) ? STEP_1 : STEP_0;
  assign bit_adv   = (step_q == STEP_0) ? bit_q : (bit_q - BW'(1));

  // Base multiplied in on the STEP_1 of each exponent iteration; a zero bit
  // multiplies by one so every iteration costs the same.
  always_comb begin
    exp_bsel = BSEL_ONE;
    exp_b    = ONE;
    case (state_q)
`ifdef SHAMIR_TRICK_EN
      ST_EXP:  exp_bsel = shamir_bsel(u1_q[bit_q], u2_q[bit_q]);
`else
      ST_EXPG: exp_bsel = shamir_bsel(u1_q[bit_q], 1'b0);
      ST_EXPY: exp_bsel = shamir_bsel(1'b0, u2_q[bit_q]);
`endif
      default: ;
    endcase
    case (exp_bsel)
      BSEL_G:  exp_b = g_q;
      BSEL_Y:  exp_b = y_q;
      BSEL_GY: exp_b = aux_q;
      default: exp_b = ONE;
    endcase
  end

  always_comb begin
    mm_a = acc_q;
    mm_b = ONE;
    mm_m = q_q;
    case (state_q)
      ST_INV: mm_b = (step_q == STEP_0) ? acc_q : (inv_e[bit_q] ? s_q : ONE);
      ST_U1: begin
        mm_a = (step_q == STEP_0) ? hm_q : acc_q;
        mm_b = (step_q == STEP_0) ? ONE : w_q;
      end
      ST_U2: begin
        mm_a = r_q;
        mm_b = w_q;
      end
`ifdef SHAMIR_TRICK_EN
      ST_EXP: begin
        mm_m = p_q;
        if (step_q == STEP_PRE) begin
          mm_a = g_q;
          mm_b = y_q;
        end else begin
          mm_b = (step_q == STEP_0) ? acc_q : exp_b;
        end
      end
`else
      ST_EXPG, ST_EXPY: begin
        mm_m = p_q;
        mm_b = (step_q == STEP_0) ? acc_q : exp_b;
      end
      ST_MULGY: begin
        mm_m = p_q;
        mm_a = aux_q;
        mm_b = acc_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    step_d   = step_q;
    bit_d    = bit_q;
    p_d      = p_q;
    q_d      = q_q;
    g_d      = g_q;
    y_d      = y_q;
    hm_d     = hm_q;
    r_d      = r_q;
    s_d      = s_q;
    w_d      = w_q;
    u1_d     = u1_q;
    u2_d     = u2_q;
    acc_d    = acc_q;
    aux_d    = aux_q;
    valid_d  = valid_q;
    mm_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          p_d     = p;
          q_d     = q;
          g_d     = g;
          y_d     = y;
          hm_d    = Hm;
          r_d     = r;
          s_d     = s;
          valid_d = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sig_bad) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          acc_d   = ONE;
          bit_d   = BIT_TOP;
          step_d  = STEP_0;
          state_d = ST_INV;
        end
      end
      ST_CMP: begin
        valid_d = (acc_q == r_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!en) state_d = ST_IDLE;
      end
      default: begin
        // Arithmetic states: issue one multiply, then consume its result.
        if (!wait_q) begin
          mm_start = 1'b1;
          wait_d   = 1'b1;
        end else if (mm_done) begin
          wait_d = 1'b0;
          case (state_q)
            ST_INV: begin
              acc_d = mm_res;
              if (!loop_last) begin
                step_d = step_adv;
                bit_d  = bit_adv;
              end else begin
                w_d     = mm_res;
                step_d  = STEP_0;
                state_d = ST_U1;
              end
            end
            ST_U1: begin
              if (step_q == STEP_0) begin
                acc_d  = mm_res;
                step_d = STEP_1;
              end else begin
                u1_d    = mm_res;
                state_d = ST_U2;
              end
            end
            ST_U2: begin
              u2_d  = mm_res;
              acc_d = ONE;
              bit_d = BIT_TOP;
`ifdef SHAMIR_TRICK_EN
              step_d  = STEP_PRE;
              state_d = ST_EXP;
`else
              step_d  = STEP_0;
              state_d = ST_EXPG;
`endif
            end
`ifdef SHAMIR_TRICK_EN
            ST_EXP: begin
              if (step_q == STEP_PRE) begin
                aux_d  = mm_res;
                step_d = STEP_0;
              end else begin
                acc_d = mm_res;
                if (!loop_last) begin
                  step_d = step_adv;
                  bit_d  = bit_adv;
                end else begin
                  state_d = ST_RED;
                end
              end
            end
`else
            ST_EXPG: begin
              acc_d = mm_res;
              if (!loop_last) begin
                step_d = step_adv;
                bit_d  = bit_adv;
              end else begin
                aux_d   = mm_res;
                acc_d   = ONE;
                bit_d   = BIT_TOP;
                step_d  = STEP_0;
                state_d = ST_EXPY;
              end
            end
            ST_EXPY: begin
              acc_d = mm_res;
              if (!loop_last) begin
                step_d = step_adv;
                bit_d  = bit_adv;
              end else begin
                state_d = ST_MULGY;
              end
            end
            ST_MULGY: begin
              acc_d   = mm_res;
              state_d = ST_RED;
            end
`endif
            ST_RED: begin
              acc_d   = mm_res;
              state_d = ST_CMP;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b0;
      step_q  <= STEP_0;
      bit_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      g_q     <= '0;
      y_q     <= '0;
      hm_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      w_q     <= '0;
      u1_q    <= '0;
      u2_q    <= '0;
      acc_q   <= '0;
      aux_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      q_q     <= q_d;
      g_q     <= g_d;
      y_q     <= y_d;
      hm_q    <= hm_d;
      r_q     <= r_d;
      s_q     <= s_d;
      w_q     <= w_d;
      u1_q    <= u1_d;
      u2_q    <= u2_d;
      acc_q   <= acc_d;
      aux_q   <= aux_d;
      valid_q <= valid_d;
    end
  end

  dsa_mod_mul #(
    .W(W)
  ) u_mod_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mm_m),
    .done  (mm_done),
    .res   (mm_res)
  );

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign valid = done && valid_q;

endmodule

// File: tb/tb_dsa_verify.sv
// tb/tb_dsa_verify.sv - self-checking bench for dsa_verify at a reduced width
module tb_dsa_verify;

  localparam int unsigned TW = 10;
  // Multiplies per accepted-range verify: inverse 2W, u1 2, u2 1, red 1, plus
  // exponentiation 2W+1 (joint pass with g*y precompute) or 4W+1 (separate).
`ifdef SHAMIR_TRICK_EN
  localparam int NMUL = 4 * TW + 5;
`else
  localparam int NMUL = 6 * TW + 5;
`endif
  // Samples (negedges) from raising en to first done=1: launch, CHECK,
  // NMUL multiplies of TW+2 cycles each, CMP. Range-rejected inputs take 2.
  localparam int LAT     = NMUL * (TW + 2) + 3;
  localparam int LAT_BAD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [TW-1:0] p = '0, q = '0, g = '0, y = '0, hm = '0, r = '0, s = '0;
  logic          busy, done, valid;

  int total = 0;
  int bad   = 0;
  int ms_cnt = 0;

  int pt[7] = '{23, 47, 59, 83, 107, 167, 983};
  int qt[7] = '{11, 23, 29, 41, 53, 83, 491};

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.mm_start === 1'b1) ms_cnt <= ms_cnt + 1;

  dsa_verify #(.W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .p     (p),
    .q     (q),
    .g     (g),
    .y     (y),
    .Hm    (hm),
    .r     (r),
    .s     (s),
    .busy  (busy),
    .done  (done),
    .valid (valid)
  );

  function automatic longint modpow(longint b, longint e, longint m);
    longint res = 1;
    longint bb = b % m;
    longint ee = e;
    while (ee > 0) begin
      if ((ee % 2) == 1) res = (res * bb) % m;
      bb = (bb * bb) % m;
      ee = ee / 2;
    end
    return res % m;
  endfunction

  function automatic bit range_bad(int vq, int vr, int vs);
    return (vr == 0) || (vr >= vq) || (vs == 0) || (vs >= vq);
  endfunction

  function automatic bit ref_verify(int vp, int vq, int vg, int vy, int vh, int vr, int vs);
    longint w, u1, u2, v;
    if (range_bad(vq, vr, vs)) return 1'b0;
    w  = modpow(vs, vq - 2, vq);
    u1 = ((vh % vq) * w) % vq;
    u2 = (longint'(vr) * w) % vq;
    v  = ((modpow(vg, u1, vp) * modpow(vy, u2, vp)) % vp) % vq;
    return v == vr;
  endfunction

  // Drives inputs, raises en and waits for done. Inputs are scrambled right
  // after launch; en is left high on return.
  task automatic run_verify(input int vp, vq, vg, vy, vh, vr, vs,
                            output int lat, output logic res, output logic busy1);
    p = TW'(vp); q = TW'(vq); g = TW'(vg); y = TW'(vy);
    hm = TW'(vh); r = TW'(vr); s = TW'(vs);
    en = 1'b1;
    lat = -1;
    res = 1'bx;
    busy1 = 1'bx;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk);
      if (i == 1) begin
        busy1 = busy;
        p = TW'($urandom); q = TW'($urandom); g = TW'($urandom); y = TW'($urandom);
        hm = TW'($urandom); r = TW'($urandom); s = TW'($urandom);
      end
      if (done === 1'b1) begin
        lat = i;
        res = valid;
        break;
      end
    end
  endtask

  task automatic drop_en();
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: busy/done/valid=%b required 000", {busy, done, valid});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_outputs: busy/done/valid=%b required 000", {busy, done, valid});
    end
  endtask

  task automatic test_accept();
    int lat; logic res, b1;
    run_verify(23, 11, 2, 9, 10, 2, 6, lat, res, b1);
    total++;
    if (b1 !== 1'b1) begin bad++; $display("FAIL accept_busy_after_launch: busy=%b required 1", b1); end
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL accept_latency: got %0d required %0d", lat, LAT); end
    total++;
    if (res !== 1'b1) begin bad++; $display("FAIL accept_valid: got %b required 1", res); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL accept_busy_in_done: busy=%b required 0", busy); end
    drop_en();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL accept_release: done=%b required 0", done); end
  endtask

  task automatic test_reject();
    int lat; logic res, b1;
    run_verify(23, 11, 2, 9, 10, 2, 7, lat, res, b1);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL reject_latency: got %0d required %0d", lat, LAT); end
    total++;
    if (res !== 1'b0) begin bad++; $display("FAIL reject_valid: got %b required 0", res); end
    drop_en();
  endtask

  task automatic test_range_check();
    int vr[3] = '{0, 11, 2};
    int vs[3] = '{6, 6, 11};
    int lat, ms0; logic res, b1;
    for (int i = 0; i < 3; i++) begin
      ms0 = ms_cnt;
      run_verify(23, 11, 2, 9, 10, vr[i], vs[i], lat, res, b1);
      total++;
      if (lat !== LAT_BAD) begin bad++; $display("FAIL range_latency[%0d]: got %0d required %0d", i, lat, LAT_BAD); end
      total++;
      if (res !== 1'b0) begin bad++; $display("FAIL range_valid[%0d]: got %b required 0", i, res); end
      total++;
      if (ms_cnt !== ms0) begin bad++; $display("FAIL range_no_mul[%0d]: starts=%0d required 0", i, ms_cnt - ms0); end
      drop_en();
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic res, b1;
    p = TW'(23); q = TW'(11); g = TW'(2); y = TW'(9); hm = TW'(10); r = TW'(2); s = TW'(6);
    en = 1'b1;
    repeat (400) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy: busy=%b required 1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, valid} !== 3'b000) begin
      bad++;
      $display("FAIL midrun_reset_immediate: busy/done/valid=%b required 000", {busy, done, valid});
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, valid} !== 3'b000) begin
      bad++;
      $display("FAIL midrun_after_reset: busy/done/valid=%b required 000", {busy, done, valid});
    end
    run_verify(23, 11, 2, 9, 10, 2, 6, lat, res, b1);
    total++;
    if (lat !== LAT || res !== 1'b1) begin
      bad++;
      $display("FAIL midrun_relaunch: lat=%0d valid=%b required lat=%0d valid=1", lat, res, LAT);
    end
    drop_en();
  endtask

  task automatic test_en_hold();
    int lat, ms0; logic res, b1;
    run_verify(23, 11, 2, 9, 10, 2, 6, lat, res, b1);
    ms0 = ms_cnt;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, valid} !== 3'b011) begin
        bad++;
        $display("FAIL hold_done[%0d]: busy/done/valid=%b required 011", i, {busy, done, valid});
      end
    end
    total++;
    if (ms_cnt !== ms0) begin bad++; $display("FAIL hold_no_relaunch: starts=%0d required 0", ms_cnt - ms0); end
    drop_en();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL hold_release: done=%b required 0", done); end
    run_verify(23, 11, 2, 9, 10, 2, 6, lat, res, b1);
    total++;
    if (lat !== LAT || res !== 1'b1) begin
      bad++;
      $display("FAIL hold_second_verify: lat=%0d valid=%b required lat=%0d valid=1", lat, res, LAT);
    end
    drop_en();
  endtask

  task automatic test_random();
    int idx, vp, vq, vg, vy, vh, vr, vs, x, k, kinv, lat, elat;
    logic res, b1, expv;
    for (int it = 0; it < 12; it++) begin
      idx = $urandom_range(0, 6);
      vp = pt[idx];
      vq = qt[idx];
      vg = 1;
      for (int t = 0; t < 50 && vg == 1; t++)
        vg = int'(modpow($urandom_range(2, vp - 2), (vp - 1) / vq, vp));
      x  = $urandom_range(1, vq - 1);
      vy = int'(modpow(vg, x, vp));
      vh = $urandom_range(0, 1023);
      vr = 0;
      vs = 0;
      for (int t = 0; t < 50 && (vr == 0 || vs == 0); t++) begin
        k    = $urandom_range(1, vq - 1);
        vr   = int'(modpow(vg, k, vp) % vq);
        kinv = int'(modpow(k, vq - 2, vq));
        vs   = int'((longint'(kinv) * ((vh % vq + longint'(x) * vr) % vq)) % vq);
      end
      case (it % 4)
        1: vs = (vs % (vq - 1)) + 1;
        2: vh = vh ^ $urandom_range(1, 1023);
        3: vr = vq + $urandom_range(0, 1023 - vq);
        default: ;
      endcase
      expv = ref_verify(vp, vq, vg, vy, vh, vr, vs);
      elat = range_bad(vq, vr, vs) ? LAT_BAD : LAT;
      run_verify(vp, vq, vg, vy, vh, vr, vs, lat, res, b1);
      total++;
      if (res !== expv || lat !== elat) begin
        bad++;
        $display("FAIL random[%0d] p=%0d q=%0d g=%0d y=%0d h=%0d r=%0d s=%0d: valid=%b lat=%0d required valid=%b lat=%0d",
                 it, vp, vq, vg, vy, vh, vr, vs, res, lat, expv, elat);
      end
      drop_en();
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_reject();
    test_range_check();
    test_reset_mid();
    test_en_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
